// File: rtl/trigger_resp_framer.sv
// ============================================================================
// Module   : trigger_resp_framer
// Purpose  : Frames one command-handler response as SYNC,TYPE,LEN,payload[,CHK]
//            onto a valid/ready byte stream; RESP_CHECKSUM_EN appends CHK.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trigger_resp_framer #(
    parameter logic [7:0]  SYNC           = 8'h7E,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [1:0]  resp_type,
    input  logic [2:0]  resp_len,
    input  logic [31:0] resp_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_abort
);

    localparam int                   C_STALL_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [C_STALL_W-1:0] C_STALL_LAST = C_STALL_W'(TIMEOUT_CYCLES - 1);
    localparam logic [C_STALL_W-1:0] C_STALL_ONE  = C_STALL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_TYPE    = 3'd2,
        S_LEN     = 3'd3,
        S_PAYLOAD = 3'd4
`ifdef RESP_CHECKSUM_EN
        ,
        S_CHK     = 3'd5
`endif
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_type;
    logic [2:0]           r_len;
    logic [31:0]          r_data;
    logic [1:0]           r_idx;
    logic [1:0]           w_idx_nxt;
    logic [7:0]           r_tx_data;
    logic [7:0]           w_tx_data_nxt;
    logic                 r_tx_valid;
    logic                 w_tx_valid_nxt;
    logic                 r_tx_abort;
    logic                 w_tx_abort_nxt;
    logic                 r_resp_ready;
    logic [C_STALL_W-1:0] r_stall;
    logic [C_STALL_W-1:0] w_stall_nxt;
    logic                 w_frame_end;

    logic       w_accept;
    logic       w_hs;
    logic       w_stall;
    logic [2:0] w_len_clamp;
    logic [1:0] w_len_idx;
    logic [1:0] w_idx_dn;

    assign w_accept    = resp_valid && r_resp_ready && (r_state == S_IDLE);
    assign w_hs        = r_tx_valid && tx_ready;
    assign w_stall     = r_tx_valid && !tx_ready;
    assign w_len_clamp = (resp_len > 3'd4) ? 3'd4 : resp_len;
    // First payload index is len-1; the 2-bit wrap maps len=4 onto index 3.
    assign w_len_idx   = r_len[1:0] - 2'd1;
    assign w_idx_dn    = r_idx - 2'd1;

`ifdef RESP_CHECKSUM_EN
    logic [7:0] r_chk;
    logic [7:0] w_chk_acc;

    always_comb begin
        w_chk_acc = {6'b0, resp_type} ^ {5'b0, w_len_clamp};
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_len_clamp) begin
                w_chk_acc = w_chk_acc ^ resp_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chk <= 8'h00;
        end else if (w_accept) begin
            r_chk <= w_chk_acc;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_type <= 2'd0;
            r_len  <= 3'd0;
            r_data <= 32'd0;
        end else if (w_accept) begin
            r_type <= resp_type;
            r_len  <= w_len_clamp;
            r_data <= resp_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_tx_data    <= 8'h00;
            r_tx_valid   <= 1'b0;
            r_tx_abort   <= 1'b0;
            r_stall      <= '0;
            r_resp_ready <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_tx_abort   <= w_tx_abort_nxt;
            r_stall      <= w_stall_nxt;
            r_resp_ready <= (w_state_nxt == S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_tx_abort_nxt = 1'b0;
        w_stall_nxt    = r_stall;
        w_frame_end    = 1'b0;

        // Each state loads the byte of the state it moves into, keeping tx_data registered.
        case (r_state)
            S_IDLE: begin
                w_tx_valid_nxt = 1'b0;
                w_stall_nxt    = '0;
                if (w_accept) begin
                    w_state_nxt    = S_SYNC;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_data_nxt  = SYNC;
                end
            end
            S_SYNC: begin
                if (w_hs) begin
                    w_state_nxt   = S_TYPE;
                    w_tx_data_nxt = {6'b0, r_type};
                end
            end
            S_TYPE: begin
                if (w_hs) begin
                    w_state_nxt   = S_LEN;
                    w_tx_data_nxt = {5'b0, r_len};
                end
            end
            S_LEN: begin
                if (w_hs) begin
                    if (r_len != 3'd0) begin
                        w_state_nxt   = S_PAYLOAD;
                        w_idx_nxt     = w_len_idx;
                        w_tx_data_nxt = r_data[{w_len_idx, 3'b000} +: 8];
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_hs) begin
                    if (r_idx != 2'd0) begin
                        w_idx_nxt     = w_idx_dn;
                        w_tx_data_nxt = r_data[{w_idx_dn, 3'b000} +: 8];
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
`ifdef RESP_CHECKSUM_EN
            S_CHK: begin
                if (w_hs) begin
                    w_state_nxt    = S_IDLE;
                    w_tx_valid_nxt = 1'b0;
                end
            end
`endif
            default: begin
                w_state_nxt    = S_IDLE;
                w_tx_valid_nxt = 1'b0;
            end
        endcase

        if (w_frame_end) begin
`ifdef RESP_CHECKSUM_EN
            w_state_nxt   = S_CHK;
            w_tx_data_nxt = r_chk;
`else
            w_state_nxt    = S_IDLE;
            w_tx_valid_nxt = 1'b0;
`endif
        end

        // A handshake always clears the stall count, even on the would-be limit cycle.
        if (r_state != S_IDLE) begin
            if (w_hs) begin
                w_stall_nxt = '0;
            end else if (w_stall) begin
                if (r_stall == C_STALL_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_tx_valid_nxt = 1'b0;
                    w_tx_abort_nxt = 1'b1;
                    w_stall_nxt    = '0;
                end else begin
                    w_stall_nxt = r_stall + C_STALL_ONE;
                end
            end
        end
    end

    assign resp_ready = r_resp_ready;
    assign tx_data    = r_tx_data;
    assign tx_valid   = r_tx_valid;
    assign tx_abort   = r_tx_abort;
    assign tx_busy    = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_trigger_resp_framer.sv
// ============================================================================
// Module   : tb_trigger_resp_framer
// Purpose  : Directed vector bench for trigger_resp_framer (either CHK build).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trigger_resp_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [1:0]  resp_type = 2'd0;
    logic [2:0]  resp_len = 3'd0;
    logic [31:0] resp_data = 32'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_busy;
    logic        tx_abort;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trigger_resp_framer #(
        .SYNC           (8'h7E),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_type  (resp_type),
        .resp_len   (resp_len),
        .resp_data  (resp_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .tx_abort   (tx_abort)
    );

    typedef struct {
        logic [1:0]       typ;
        logic [2:0]       len;
        logic [31:0]      data;
        int               stall;
        int               nb;
        logic [0:7][7:0]  b;
        logic [7:0]       chk;
    } vec_t;

    vec_t vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns on the negedge after the accept edge, with resp_* scrambled to prove capture.
    task automatic send(input logic [1:0] typ, input logic [2:0] len, input logic [31:0] data);
        int k;
        k = 0;
        while (!resp_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("resp_ready_wait", {31'd0, resp_ready}, 32'd1);
        resp_valid = 1'b1;
        resp_type  = typ;
        resp_len   = len;
        resp_data  = data;
        @(negedge clk);
        resp_valid = 1'b0;
        resp_type  = ~typ;
        resp_len   = ~len;
        resp_data  = ~data;
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] exp_b [9];
        int n;
        for (int i = 0; i < v.nb; i++) exp_b[i] = v.b[i];
        n = v.nb;
`ifdef RESP_CHECKSUM_EN
        exp_b[n] = v.chk;
        n++;
`endif
        send(v.typ, v.len, v.data);
        for (int i = 0; i < n; i++) begin
            if (v.stall > 0) begin
                tx_ready = 1'b0;
                for (int s = 0; s < v.stall; s++) begin
                    check($sformatf("stall_valid%0d", i), {31'd0, tx_valid}, 32'd1);
                    check($sformatf("stall_data%0d", i), {24'd0, tx_data}, {24'd0, exp_b[i]});
                    @(negedge clk);
                end
                tx_ready = 1'b1;
            end
            check($sformatf("valid%0d", i), {31'd0, tx_valid}, 32'd1);
            check($sformatf("byte%0d", i), {24'd0, tx_data}, {24'd0, exp_b[i]});
            check($sformatf("busy%0d", i), {30'd0, tx_busy, resp_ready}, 32'd2);
            @(negedge clk);
        end
        check("end_valid", {31'd0, tx_valid}, 32'd0);
        check("end_busy", {31'd0, tx_busy}, 32'd0);
        check("end_ready", {31'd0, resp_ready}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int abort_at;
        int n_abort;

        vec[0] = '{2'd0, 3'd0, 32'h0000_0000, 0, 3, {8'h7E, 8'h00, 8'h00, 40'h0}, 8'h00};
        vec[1] = '{2'd2, 3'd4, 32'h1234_5678, 0, 7, {8'h7E, 8'h02, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00}, 8'h0E};
        vec[2] = '{2'd2, 3'd2, 32'hAABB_CCDD, 5, 5, {8'h7E, 8'h02, 8'h02, 8'hCC, 8'hDD, 24'h0}, 8'h11};
        vec[3] = '{2'd1, 3'd7, 32'hDEAD_BEEF, 0, 7, {8'h7E, 8'h01, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00}, 8'h27};
        vec[4] = '{2'd3, 3'd1, 32'h0000_00A5, 0, 4, {8'h7E, 8'h03, 8'h01, 8'hA5, 32'h0}, 8'hA7};
        vec[5] = '{2'd2, 3'd3, 32'h1122_3344, 1, 6, {8'h7E, 8'h02, 8'h03, 8'h22, 8'h33, 8'h44, 16'h0}, 8'h54};

        repeat (2) @(negedge clk);
        check("rst_outputs", {27'd0, resp_ready, tx_valid, tx_busy, tx_abort, 1'b0}, 32'd0);
        check("rst_data", {24'd0, tx_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'd0, resp_ready}, 32'd1);

        for (int v = 0; v < 6; v++) begin
            run_frame(vec[v]);
        end

        // Stall timeout: TYPE never accepted, abort expected after 16 stalled cycles.
        send(2'd2, 3'd2, 32'hAABB_CCDD);
        check("to_sync", {24'd0, tx_data}, 32'h7E);
        @(negedge clk);
        tx_ready = 1'b0;
        hold     = 0;
        abort_at = -1;
        n_abort  = 0;
        for (int c = 0; c < 40; c++) begin
            if (tx_valid) hold++;
            if (tx_abort) begin
                n_abort++;
                if (abort_at < 0) abort_at = c;
                check("abort_valid", {31'd0, tx_valid}, 32'd0);
            end
            @(negedge clk);
        end
        tx_ready = 1'b1;
        check("to_stall_cycles", hold, 32'd16);
        check("to_abort_cycle", abort_at, 32'd16);
        check("to_abort_count", n_abort, 32'd1);
        run_frame(vec[1]);

        // Asynchronous reset in the middle of the payload.
        send(2'd2, 3'd4, 32'h1234_5678);
        repeat (3) @(negedge clk);
        check("pre_rst_payload", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h12});
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, tx_busy}, 32'd0);
        check("mid_rst_ready", {31'd0, resp_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_frame(vec[0]);
        run_frame(vec[4]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
